// File: rtl/expand_mc_if.sv
// Sample stream bundle for expand_mc: log-PCM codes in, uniform PCM out.
// Valid/ready: a word transfers on a rising edge where valid and ready are both high.
interface expand_mc_if #(
    parameter int CH_W = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      sin;
    logic [CH_W-1:0] in_ch;
    logic            out_valid;
    logic            out_ready;
    logic [13:0]     sout;
    logic [CH_W-1:0] out_ch;

    modport master (
        output in_valid, sin, in_ch, out_ready,
        input  in_ready, out_valid, sout, out_ch
    );

    modport slave (
        input  in_valid, sin, in_ch, out_ready,
        output in_ready, out_valid, sout, out_ch
    );
endinterface

// File: rtl/expand_mc.sv
// Multi-channel G.711 expander: input FIFO, per-channel law bank, two-stage
// pipeline producing 14-bit two's-complement uniform PCM.
module expand_mc #(
    parameter  int CHANNELS   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = AW + 1
) (
    input  logic                test_clk,
    input  logic                reset_n,
    expand_mc_if.slave          bus,
    input  logic                law_we,
    input  logic [CH_W-1:0]     law_ch,
    input  logic                law_val,
    output logic [CHANNELS-1:0] law_cfg,
    output logic [LVL_W-1:0]    level
);

    logic [CH_W+7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic             s1_valid;
    logic             s1_pos;
    logic             s1_law;
    logic [2:0]       s1_exp;
    logic [3:0]       s1_man;
    logic [CH_W-1:0]  s1_ch;

    logic             s1_adv;
    logic             s2_adv;

    logic [CH_W+7:0]  head;
    logic [7:0]       h_code;
    logic [CH_W-1:0]  h_ch;
    logic             h_law;
    logic [7:0]       h_x;

    logic [13:0]      base;
    logic [13:0]      shifted;
    logic [13:0]      mag;
    logic [13:0]      pcm;

    assign full         = (count == LVL_W'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign bus.in_ready = !full;
    assign level        = count;

    // Pipeline advance chain: stage 2 moves when empty or drained, stage 1 when stage 2 moves.
    assign s2_adv = !bus.out_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign push   = bus.in_valid && !full;
    assign pop    = !empty && s1_adv;

    always_ff @(posedge test_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.in_ch, bus.sin};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Law bank; tags outside the channel range match no entry and are dropped.
    always_ff @(posedge test_clk or negedge reset_n) begin
        if (!reset_n) begin
            law_cfg <= '0;
        end else if (law_we) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (law_ch == CH_W'(i)) law_cfg[i] <= law_val;
            end
        end
    end

    // Head-of-FIFO decode; the law is read before any same-edge bank write lands.
    always_comb begin
        head   = mem[rd_ptr];
        h_code = head[7:0];
        h_ch   = head[CH_W+7:8];
        h_law  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (h_ch == CH_W'(i)) h_law = law_cfg[i];
        end
        h_x = h_law ? (h_code ^ 8'h55) : ~h_code;
    end

    always_ff @(posedge test_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_pos   <= 1'b0;
            s1_law   <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
            s1_ch    <= '0;
        end else if (s1_adv) begin
            s1_valid <= pop;
            if (pop) begin
                s1_pos <= h_code[7];
                s1_law <= h_law;
                s1_exp <= h_x[6:4];
                s1_man <= h_x[3:0];
                s1_ch  <= h_ch;
            end
        end
    end

    // (2m+33) << e is shared: mu-law subtracts the bias, A-law uses it directly for e>0.
    always_comb begin
        base    = {8'd0, s1_man, 1'b1} + 14'd32;
        shifted = base << s1_exp;
        if (s1_law) mag = (s1_exp == 3'd0) ? {8'd0, s1_man, 2'b10} : shifted;
        else        mag = shifted - 14'd33;
        pcm = s1_pos ? mag : -mag;
    end

    always_ff @(posedge test_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.sout      <= '0;
            bus.out_ch    <= '0;
        end else if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.sout   <= pcm;
                bus.out_ch <= s1_ch;
            end
        end
    end

endmodule

// File: tb/tb_expand_mc.sv
// Directed bench for expand_mc: hand-computed G.711 vectors, law programming,
// backpressure, law-write race and asynchronous reset.
module tb_expand_mc;
    localparam int CH_W = 2;

    logic       test_clk = 1'b0;
    logic       reset_n;
    logic       law_we;
    logic [1:0] law_ch;
    logic       law_val;
    logic [3:0] law_cfg;
    logic [2:0] level;

    expand_mc_if #(.CH_W(CH_W)) bus ();

    expand_mc #(.CHANNELS(4), .FIFO_DEPTH(4)) dut (
        .test_clk (test_clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .law_we   (law_we),
        .law_ch   (law_ch),
        .law_val  (law_val),
        .law_cfg  (law_cfg),
        .level    (level)
    );

    always #5 test_clk = ~test_clk;

    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    logic        last_in_fire = 1'b0;
    logic [15:0] cur_exp = '0;
    logic [15:0] exp_q[$];

    // Reference vectors: ch0 entries are mu-law, ch1 entries A-law once ch1 is programmed.
    logic [1:0]  t_ch   [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [7:0]  t_code [8] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'hD5, 8'h55, 8'hAA, 8'h2A};
    logic [13:0] t_sout [8] = '{14'h20A1, 14'h1F5F, 14'h0000, 14'h0000,
                                14'h0002, 14'h3FFE, 14'h1F80, 14'h2080};
    logic        ev_valid [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are judged on the values present just before the edge.
    task automatic cycle();
        logic        fire_out;
        logic        fire_in;
        logic [15:0] obs;
        fire_out = bus.out_valid && bus.out_ready;
        fire_in  = bus.in_valid && bus.in_ready;
        obs      = {bus.out_ch, bus.sout};
        @(posedge test_clk);
        if (fire_out) begin
            if (exp_q.size() == 0) check("unexpected_out", {16'd0, obs}, 32'hFFFF_FFFF);
            else                   check("sout", {16'd0, obs}, {16'd0, exp_q.pop_front()});
        end
        last_in_fire = fire_in;
        if (fire_in) begin
            exp_q.push_back(cur_exp);
            n_acc++;
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] ch, input logic [7:0] code, input logic [15:0] exp);
        bus.in_valid = 1'b1;
        bus.in_ch    = ch;
        bus.sin      = code;
        cur_exp      = exp;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) cycle();
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i8;
        int guard;
        reset_n       = 1'b0;
        law_we        = 1'b0;
        law_ch        = '0;
        law_val       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sin       = '0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge test_clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_level", level, 0);
        check("rst_law_cfg", law_cfg, 0);
        check("rst_sout", bus.sout, 0);
        check("rst_out_ch", bus.out_ch, 0);
        reset_n = 1'b1;

        // mu-law on ch0: two-cycle latency and back-to-back output
        for (int k = 0; k < 7; k++) begin
            if (k < 4) drive(t_ch[k], t_code[k], {t_ch[k], t_sout[k]});
            else       idle();
            cycle();
            check("mu_out_valid", bus.out_valid, ev_valid[k]);
        end
        check("mu_drained", exp_q.size(), 0);

        // program ch1 to A-law
        idle();
        law_we = 1'b1; law_ch = 2'd1; law_val = 1'b1;
        cycle();
        law_we = 1'b0;
        check("law_cfg_ch1", law_cfg, 4'b0010);
        for (int k = 4; k < 8; k++) begin
            drive(t_ch[k], t_code[k], {t_ch[k], t_sout[k]});
            cycle();
        end
        drain(6);

        // interleaved channels, same code, different laws
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) drive(2'd0, 8'h80, {2'd0, 14'h1F5F});
            else            drive(2'd1, 8'h80, {2'd1, 14'h0560});
            cycle();
        end
        drain(6);

        // backpressure: ten offered, six held
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            i8 = k % 8;
            drive(t_ch[i8], t_code[i8], {t_ch[i8], t_sout[i8]});
            cycle();
        end
        idle();
        check("bp_accepted", n_acc, 6);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_level", level, 4);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_sout", bus.sout, 14'h20A1);
        repeat (3) cycle();
        check("bp_sout_stable", bus.sout, 14'h20A1);
        check("bp_out_ch_stable", bus.out_ch, 0);
        check("bp_held", exp_q.size(), 6);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("bp_drain_valid", bus.out_valid, 1);
            cycle();
        end
        check("bp_drain_done", bus.out_valid, 0);
        check("bp_drain_empty", exp_q.size(), 0);

        // random downstream readiness
        for (int k = 0; k < 12; k++) begin
            i8 = k % 8;
            drive(t_ch[i8], t_code[i8], {t_ch[i8], t_sout[i8]});
            guard = 0;
            do begin
                bus.out_ready = ($urandom_range(0, 1) == 1);
                cycle();
                guard++;
            end while (!last_in_fire && guard < 50);
            check("rand_accept", last_in_fire, 1);
        end
        bus.out_ready = 1'b1;
        drain(10);

        // law write on the same edge ch0's sample pops
        drive(2'd0, 8'h80, {2'd0, 14'h1F5F});
        cycle();
        drive(2'd0, 8'h80, {2'd0, 14'h0560});
        law_we = 1'b1; law_ch = 2'd0; law_val = 1'b1;
        cycle();
        law_we = 1'b0;
        check("law_cfg_ch0", law_cfg, 4'b0011);
        drain(6);

        // asynchronous reset with six samples in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(t_ch[k], t_code[k], {t_ch[k], t_sout[k]});
            cycle();
        end
        idle();
        check("pre_rst_level", level, 4);
        #3 reset_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_level", level, 0);
        check("arst_law_cfg", law_cfg, 0);
        check("arst_sout", bus.sout, 0);
        exp_q.delete();
        @(posedge test_clk);
        #1 reset_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        check("post_rst_quiet", bus.out_valid, 0);
        drive(2'd0, 8'h80, {2'd0, 14'h1F5F});
        cycle();
        check("post_rst_accept", last_in_fire, 1);
        drain(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
